// File: rtl/float_cmp_if.sv
// float_cmp_if: stream bundle for the floating-point comparator.
//   slave  modport : comparator side (operand/opcode sinks, result source)
//   master modport : environment side (operand/opcode sources, result sink)
// Channels: A operand, B operand, 8-bit opcode, 8-bit result.
interface float_cmp_if #(
  parameter int unsigned SIZE = 64
);
  logic [SIZE-1:0] s_axis_a_tdata;
  logic            s_axis_a_tvalid;
  logic            s_axis_a_tready;
  logic [SIZE-1:0] s_axis_b_tdata;
  logic            s_axis_b_tvalid;
  logic            s_axis_b_tready;
  logic [7:0]      s_axis_operation_tdata;
  logic            s_axis_operation_tvalid;
  logic            s_axis_operation_tready;
  logic [7:0]      m_axis_result_tdata;
  logic            m_axis_result_tvalid;
  logic            m_axis_result_tready;

  modport slave (
    input  s_axis_a_tdata, s_axis_a_tvalid,
    output s_axis_a_tready,
    input  s_axis_b_tdata, s_axis_b_tvalid,
    output s_axis_b_tready,
    input  s_axis_operation_tdata, s_axis_operation_tvalid,
    output s_axis_operation_tready,
    output m_axis_result_tdata, m_axis_result_tvalid,
    input  m_axis_result_tready
  );

  modport master (
    output s_axis_a_tdata, s_axis_a_tvalid,
    input  s_axis_a_tready,
    output s_axis_b_tdata, s_axis_b_tvalid,
    input  s_axis_b_tready,
    output s_axis_operation_tdata, s_axis_operation_tvalid,
    input  s_axis_operation_tready,
    input  m_axis_result_tdata, m_axis_result_tvalid,
    output m_axis_result_tready
  );
endinterface

// File: rtl/float_cmp.sv
// float_cmp: pipelined IEEE-754 comparator (binary32 or binary64).
// Ports:
//   aclk    : clock, rising edge
//   aresetn : synchronous reset, active-high (1 clears the pipeline)
//   bus     : float_cmp_if.slave -- joined A/B/opcode input channels and
//             the 8-bit result channel {5'b0, bad_op, unordered, predicate}
// A beat is taken when all three inputs are valid and the pipeline can
// advance; the result appears LATENCY-1 edges after the accepting edge.
module float_cmp #(
  parameter int unsigned SIZE    = 64,
  parameter int unsigned EXP_W   = 11,
  parameter int unsigned LATENCY = 3
) (
  input  logic      aclk,
  input  logic      aresetn,
  float_cmp_if.slave bus
);

  localparam int unsigned FRAC_W = SIZE - 1 - EXP_W;

  typedef enum logic [2:0] {
    OP_UN  = 3'd0,
    OP_LT  = 3'd1,
    OP_EQ  = 3'd2,
    OP_LE  = 3'd3,
    OP_GT  = 3'd4,
    OP_NE  = 3'd5,
    OP_GE  = 3'd6,
    OP_BAD = 3'd7
  } op_e;

  logic [SIZE-1:0]   a, b;
  logic              sign_a, sign_b;
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic [SIZE-2:0]   mag_a, mag_b;
  logic              nan_a, nan_b, zero_a, zero_b;
  logic              unord, both_zero, lt, eq, gt;
  logic              bad_op, pred;
  op_e               op_code;
  logic [7:0]        result;

  logic              can_advance;
  logic              accept;
  logic              stage_valid [LATENCY];
  logic [7:0]        stage_data  [LATENCY];

  assign a      = bus.s_axis_a_tdata;
  assign b      = bus.s_axis_b_tdata;
  assign sign_a = a[SIZE-1];
  assign sign_b = b[SIZE-1];
  assign exp_a  = a[SIZE-2 -: EXP_W];
  assign exp_b  = b[SIZE-2 -: EXP_W];
  assign frac_a = a[FRAC_W-1:0];
  assign frac_b = b[FRAC_W-1:0];
  assign mag_a  = a[SIZE-2:0];
  assign mag_b  = b[SIZE-2:0];

  assign nan_a     = (&exp_a) && (|frac_a);
  assign nan_b     = (&exp_b) && (|frac_b);
  assign zero_a    = ~|mag_a;
  assign zero_b    = ~|mag_b;
  assign unord     = nan_a || nan_b;
  assign both_zero = zero_a && zero_b;

  // Sign/magnitude order: unsigned {exp,frac} ranks positives, reversed for
  // negatives; the +0/-0 pair is the only case where differing signs tie.
  assign eq = !unord && (both_zero || (a == b));
  assign lt = !unord && !both_zero &&
              (( sign_a && !sign_b) ||
               (!sign_a && !sign_b && (mag_a < mag_b)) ||
               ( sign_a &&  sign_b && (mag_a > mag_b)));
  assign gt = !unord && !lt && !eq;

  assign op_code = op_e'(bus.s_axis_operation_tdata[2:0]);
  assign bad_op  = (op_code == OP_BAD) || (|bus.s_axis_operation_tdata[7:3]);

  always_comb begin
    pred = 1'b0;
    case (op_code)
      OP_UN:   pred = unord;
      OP_LT:   pred = lt;
      OP_EQ:   pred = eq;
      OP_LE:   pred = lt || eq;
      OP_GT:   pred = gt;
      OP_NE:   pred = unord || !eq;
      OP_GE:   pred = gt || eq;
      default: pred = 1'b0;
    endcase
    if (bad_op) pred = 1'b0;
  end

  assign result = {5'b00000, bad_op, unord, pred};

  assign can_advance = bus.m_axis_result_tready || !bus.m_axis_result_tvalid;
  assign accept      = can_advance && bus.s_axis_a_tvalid &&
                       bus.s_axis_b_tvalid && bus.s_axis_operation_tvalid;

  assign bus.s_axis_a_tready         = can_advance;
  assign bus.s_axis_b_tready         = can_advance;
  assign bus.s_axis_operation_tready = can_advance;

  // Global stall: every stage shifts together or holds together.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage_valid[i] <= 1'b0;
        stage_data[i]  <= '0;
      end
    end else if (can_advance) begin
      stage_valid[0] <= accept;
      stage_data[0]  <= accept ? result : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
    end
  end

  assign bus.m_axis_result_tvalid = stage_valid[LATENCY-1];
  assign bus.m_axis_result_tdata  = stage_data[LATENCY-1];

endmodule

// File: tb/tb_float_cmp.sv
// tb_float_cmp: directed + randomized bench for float_cmp.
// Instances: binary64 / LATENCY=3 and binary32 / LATENCY=1.
module tb_float_cmp;

  localparam int unsigned L64 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  float_cmp_if #(.SIZE(64)) bus64 ();
  float_cmp_if #(.SIZE(32)) bus32 ();

  float_cmp #(.SIZE(64), .EXP_W(11), .LATENCY(L64)) dut64 (
    .aclk(clk), .aresetn(rst), .bus(bus64.slave));
  float_cmp #(.SIZE(32), .EXP_W(8), .LATENCY(1)) dut32 (
    .aclk(clk), .aresetn(rst), .bus(bus32.slave));

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [7:0]  exp;
    int unsigned t;
  } entry_t;
  entry_t q[$];

  int unsigned cyc = 0;
  bit          was_rst = 1'b0;
  bit          stalled = 1'b0;
  logic [7:0]  held = '0;
  bit          acc = 1'b0;
  bit          use_dir = 1'b0;
  bit          chk_lat = 1'b0;
  logic [7:0]  dir_exp = '0;

  logic [63:0] sp [12] = '{
    64'h0000000000000000, 64'h8000000000000000, 64'h3FF0000000000000,
    64'hBFF0000000000000, 64'h7FF0000000000000, 64'hFFF0000000000000,
    64'h7FF8000000000000, 64'hFFF0000000000001, 64'h0000000000000001,
    64'h8000000000000001, 64'h000FFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference: NaN from fields, ordering from real-number comparison.
  function automatic logic [7:0] model(input logic [63:0] a, input logic [63:0] b,
                                       input logic [7:0] op);
    bit  na, nb, un, p, bad;
    real ra, rb;
    na  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    nb  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    un  = na || nb;
    ra  = $bitstoreal(a);
    rb  = $bitstoreal(b);
    bad = (op[2:0] == 3'd7) || (op[7:3] != 5'd0);
    case (op[2:0])
      3'd0:    p = un;
      3'd1:    p = !un && (ra <  rb);
      3'd2:    p = !un && (ra == rb);
      3'd3:    p = !un && (ra <= rb);
      3'd4:    p = !un && (ra >  rb);
      3'd5:    p = un  || (ra != rb);
      3'd6:    p = !un && (ra >= rb);
      default: p = 1'b0;
    endcase
    if (bad) p = 1'b0;
    return {5'b00000, bad, un, p};
  endfunction

  // Observes the state that the coming rising edge will act on.
  task automatic mon();
    bit can;
    entry_t e;
    cyc++;
    acc = 1'b0;
    if (rst) begin
      q.delete();
      was_rst = 1'b1;
      stalled = 1'b0;
      return;
    end
    if (was_rst) begin
      chk("rst_tvalid", 64'(bus64.m_axis_result_tvalid), 64'd0);
      chk("rst_tdata", 64'(bus64.m_axis_result_tdata), 64'd0);
      was_rst = 1'b0;
    end
    can = bus64.m_axis_result_tready || !bus64.m_axis_result_tvalid;
    chk("tready", {61'd0, bus64.s_axis_a_tready, bus64.s_axis_b_tready,
                   bus64.s_axis_operation_tready}, {61'd0, can, can, can});
    if (stalled) begin
      chk("stall_tvalid", 64'(bus64.m_axis_result_tvalid), 64'd1);
      chk("stall_tdata", 64'(bus64.m_axis_result_tdata), 64'(held));
    end
    if (bus64.m_axis_result_tvalid && bus64.m_axis_result_tready) begin
      if (q.size() == 0) begin
        chk("spurious_result", 64'(bus64.m_axis_result_tdata), 64'hDEAD);
      end else begin
        e = q.pop_front();
        chk("result", 64'(bus64.m_axis_result_tdata), 64'(e.exp));
        if (chk_lat) chk("latency", 64'(cyc - e.t), 64'(L64));
      end
    end
    if (can && bus64.s_axis_a_tvalid && bus64.s_axis_b_tvalid &&
        bus64.s_axis_operation_tvalid) begin
      e.exp = use_dir ? dir_exp
                      : model(bus64.s_axis_a_tdata, bus64.s_axis_b_tdata,
                              bus64.s_axis_operation_tdata);
      e.t = cyc;
      q.push_back(e);
      acc = 1'b1;
    end
    stalled = bus64.m_axis_result_tvalid && !bus64.m_axis_result_tready;
    held    = bus64.m_axis_result_tdata;
  endtask

  task automatic cycle();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic drive64(input logic [63:0] a, input logic [63:0] b, input logic [7:0] op,
                         input bit va, input bit vb, input bit vo);
    bus64.s_axis_a_tdata          = a;
    bus64.s_axis_b_tdata          = b;
    bus64.s_axis_operation_tdata  = op;
    bus64.s_axis_a_tvalid         = va;
    bus64.s_axis_b_tvalid         = vb;
    bus64.s_axis_operation_tvalid = vo;
  endtask

  task automatic drain(input string tag);
    int unsigned k;
    drive64('0, '0, '0, 0, 0, 0);
    bus64.m_axis_result_tready = 1'b1;
    k = 0;
    while (q.size() != 0 && k < 50) begin
      cycle();
      k++;
    end
    cycle();
    cycle();
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  function automatic logic [63:0] rand_opnd();
    int unsigned r;
    r = $urandom_range(0, 3);
    if (r < 2) return sp[$urandom_range(0, 11)];
    return {$urandom, $urandom};
  endfunction

  function automatic logic [7:0] rand_op();
    logic [4:0] hi;
    logic [2:0] lo;
    hi = 5'($urandom_range(1, 31));
    lo = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 9) == 0) return {hi, lo};
    return {5'd0, lo};
  endfunction

  logic [63:0] ca, cb;
  logic [7:0]  co;

  task automatic new_beat();
    int unsigned r;
    ca = rand_opnd();
    r  = $urandom_range(0, 5);
    if (r == 0)      cb = ca;
    else if (r == 1) cb = ca ^ 64'h8000000000000000;
    else if (r == 2) cb = ca ^ 64'h0000000000000001;
    else             cb = rand_opnd();
    co = rand_op();
  endtask

  // Directed binary64 vectors with their required result bytes.
  logic [63:0] da [10] = '{
    64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0000000000000000,
    64'h0000000000000000, 64'h7FF8000000000000, 64'h7FF8000000000000,
    64'h7FF8000000000000, 64'hBFF0000000000000, 64'hBFF0000000000000,
    64'hBFF0000000000000};
  logic [63:0] db [10] = '{
    64'h4000000000000000, 64'h4000000000000000, 64'h8000000000000000,
    64'h8000000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000,
    64'h3FF0000000000000, 64'hC000000000000000, 64'hC000000000000000,
    64'hC000000000000000};
  logic [7:0] dop [10] = '{8'h01, 8'h04, 8'h02, 8'h01, 8'h05, 8'h00, 8'h06,
                           8'h04, 8'h07, 8'h09};
  logic [7:0] dex [10] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h03, 8'h03, 8'h02,
                           8'h01, 8'h04, 8'h04};

  logic [31:0] sa [3] = '{32'h3F800000, 32'hBF800000, 32'h7FC00000};
  logic [31:0] sb [3] = '{32'h7F800000, 32'h00000000, 32'h3F800000};
  logic [7:0]  sop [3] = '{8'h03, 8'h01, 8'h02};
  logic [7:0]  sex [3] = '{8'h01, 8'h01, 8'h02};

  initial begin
    int unsigned n, k;
    drive64('0, '0, '0, 0, 0, 0);
    bus64.m_axis_result_tready    = 1'b1;
    bus32.s_axis_a_tdata          = '0;
    bus32.s_axis_b_tdata          = '0;
    bus32.s_axis_operation_tdata  = '0;
    bus32.s_axis_a_tvalid         = 1'b0;
    bus32.s_axis_b_tvalid         = 1'b0;
    bus32.s_axis_operation_tvalid = 1'b0;
    bus32.m_axis_result_tready    = 1'b1;

    // Reset, then directed vectors back to back with latency checks.
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    use_dir = 1'b1;
    chk_lat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dir_exp = dex[i];
      drive64(da[i], db[i], dop[i], 1, 1, 1);
      cycle();
    end
    drain("directed_drain");

    // Ten-beat stream, random downstream stalls, B valid gap mid-stream.
    use_dir = 1'b0;
    chk_lat = 1'b0;
    new_beat();
    n = 0;
    k = 0;
    while (n < 10 && k < 300) begin
      drive64(ca, cb, co, 1, !(k == 4 || k == 5), 1);
      bus64.m_axis_result_tready = 1'($urandom_range(0, 1));
      cycle();
      k++;
      if (acc) begin
        n++;
        new_beat();
      end
    end
    chk("stream_beats", 64'(n), 64'd10);
    drain("stream_drain");

    // Longer random run with independent channel valids.
    n = 0;
    k = 0;
    new_beat();
    while (n < 200 && k < 5000) begin
      drive64(ca, cb, co, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0);
      bus64.m_axis_result_tready = ($urandom_range(0, 9) < 7);
      cycle();
      k++;
      if (acc) begin
        n++;
        new_beat();
      end
    end
    chk("random_beats", 64'(n), 64'd200);
    drain("random_drain");

    // Reset with two beats in flight; afterwards a fresh beat at full latency.
    bus64.m_axis_result_tready = 1'b1;
    drive64(64'h3FF0000000000000, 64'h4000000000000000, 8'h01, 1, 1, 1);
    cycle();
    drive64(64'h4000000000000000, 64'h3FF0000000000000, 8'h04, 1, 1, 1);
    cycle();
    drive64('0, '0, '0, 0, 0, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk_lat = 1'b1;
    drive64(64'hBFF0000000000000, 64'h3FF0000000000000, 8'h03, 1, 1, 1);
    cycle();
    drain("post_reset_drain");
    chk_lat = 1'b0;

    // binary32 instance, one-cycle latency.
    for (int i = 0; i < 3; i++) begin
      bus32.s_axis_a_tdata          = sa[i];
      bus32.s_axis_b_tdata          = sb[i];
      bus32.s_axis_operation_tdata  = sop[i];
      bus32.s_axis_a_tvalid         = 1'b1;
      bus32.s_axis_b_tvalid         = 1'b1;
      bus32.s_axis_operation_tvalid = 1'b1;
      @(negedge clk);
      chk("s32_idle_tvalid", 64'(bus32.m_axis_result_tvalid), 64'd0);
      @(posedge clk);
      #1;
      bus32.s_axis_a_tvalid         = 1'b0;
      bus32.s_axis_b_tvalid         = 1'b0;
      bus32.s_axis_operation_tvalid = 1'b0;
      @(negedge clk);
      chk("s32_tvalid", 64'(bus32.m_axis_result_tvalid), 64'd1);
      chk("s32_tdata", 64'(bus32.m_axis_result_tdata), 64'(sex[i]));
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
